// File: rtl/load_store_unit.sv
// Load/store unit driving a byte-enabled word memory with combinational read.
// Handles RISC-V B/H/W loads and stores, and splits word-crossing accesses in two.
module load_store_unit #(
  parameter int unsigned DATA_BITS = 10
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [2:0]           req_funct3,
  input  logic [31:0]          req_addr,
  input  logic [31:0]          req_wdata,
  output logic                 resp_valid,
  output logic [31:0]          resp_rdata,
  output logic                 resp_error,
  output logic [DATA_BITS-3:0] mem_address,
  output logic [3:0]           mem_byteena,
  output logic [31:0]          mem_data,
  output logic                 mem_wren,
  input  logic [31:0]          mem_q
);

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

  localparam logic [DATA_BITS-3:0] WORD_ONE = 1;

  state_t               state;
  logic                 wr;
  logic [2:0]           f3;
  logic [DATA_BITS-1:0] addr;
  logic [31:0]          wdata;
  logic [31:0]          buffer;

  logic [1:0]           off;
  logic [4:0]           sh;
  logic [3:0]           nmask;
  logic [7:0]           lanes;
  logic                 crossing;
  logic [DATA_BITS-3:0] word;
  logic [31:0]          rot_wdata;
  logic [31:0]          merged;
  logic [31:0]          aligned;
  logic [31:0]          loaded;
  logic                 illegal;
  logic                 unused_addr_bits;

  assign unused_addr_bits = ^req_addr[31:DATA_BITS];

  assign off  = addr[1:0];
  assign sh   = {off, 3'b000};
  assign word = addr[DATA_BITS-1:2];

  always_comb begin
    case (f3[1:0])
      2'b00:   nmask = 4'b0001;
      2'b01:   nmask = 4'b0011;
      default: nmask = 4'b1111;
    endcase
  end

  // Upper nibble of the shifted mask is exactly the second-word lane set.
  assign lanes    = {4'b0000, nmask} << off;
  assign crossing = |lanes[7:4];

  assign rot_wdata = (wdata << sh) | (wdata >> (6'd32 - {1'b0, sh}));

  always_comb begin
    mem_address = '0;
    mem_byteena = '0;
    mem_data    = '0;
    mem_wren    = 1'b0;
    case (state)
      ACC0: begin
        mem_address = word;
        mem_byteena = lanes[3:0];
        mem_wren    = wr;
        mem_data    = wr ? rot_wdata : '0;
      end
      ACC1: begin
        mem_address = word + WORD_ONE;
        mem_byteena = lanes[7:4];
        mem_wren    = wr;
        mem_data    = wr ? rot_wdata : '0;
      end
      default: ;
    endcase
  end

  always_comb begin
    merged = buffer;
    for (int unsigned i = 0; i < 4; i++) begin
      if (mem_byteena[i] && !wr) merged[8*i +: 8] = mem_q[8*i +: 8];
    end
  end

  assign aligned = (merged >> sh) | (merged << (6'd32 - {1'b0, sh}));

  always_comb begin
    case (f3)
      3'b000:  loaded = {{24{aligned[7]}}, aligned[7:0]};
      3'b001:  loaded = {{16{aligned[15]}}, aligned[15:0]};
      3'b100:  loaded = {24'h000000, aligned[7:0]};
      3'b101:  loaded = {16'h0000, aligned[15:0]};
      default: loaded = aligned;
    endcase
  end

  assign illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
                   (req_write && req_funct3[2]);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      wr         <= 1'b0;
      f3         <= '0;
      addr       <= '0;
      wdata      <= '0;
      buffer     <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_error <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            wr        <= req_write;
            f3        <= req_funct3;
            addr      <= req_addr[DATA_BITS-1:0];
            wdata     <= req_wdata;
            buffer    <= '0;
            req_ready <= 1'b0;
            if (illegal) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_error <= 1'b1;
              resp_rdata <= '0;
            end else begin
              state <= ACC0;
            end
          end
        end
        ACC0, ACC1: begin
          buffer <= merged;
          if (state == ACC0 && crossing) begin
            state <= ACC1;
          end else begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_error <= 1'b0;
            resp_rdata <= wr ? '0 : loaded;
          end
        end
        RESP: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a behavioural byte-lane memory.
module tb_load_store_unit;

  localparam int unsigned DB = 10;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [2:0]    req_funct3 = '0;
  logic [31:0]   req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          resp_error;
  logic [DB-3:0] mem_address;
  logic [3:0]    mem_byteena;
  logic [31:0]   mem_data;
  logic          mem_wren;
  logic [31:0]   mem_q;

  logic [31:0]   mem [256];

  int checks = 0;
  int failures = 0;

  load_store_unit #(.DATA_BITS(DB)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
    .mem_address(mem_address), .mem_byteena(mem_byteena), .mem_data(mem_data),
    .mem_wren(mem_wren), .mem_q(mem_q)
  );

  always #5 clock = ~clock;

  assign mem_q = mem[mem_address];

  always @(posedge clock) begin
    if (mem_wren) begin
      for (int i = 0; i < 4; i++)
        if (mem_byteena[i]) mem[mem_address][8*i +: 8] <= mem_data[8*i +: 8];
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Presents one request in IDLE; returns 1 time unit after the accept edge.
  task automatic issue(input logic w, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
    @(negedge clock);
    req_write = w; req_funct3 = f; req_addr = a; req_wdata = d; req_valid = 1'b1;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++; if ({req_ready, resp_valid, resp_error} !== 3'b100) begin failures++; $display("FAIL reset_flags got=%b exp=100", {req_ready, resp_valid, resp_error}); end
    checks++; if (resp_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=00000000", resp_rdata); end
    checks++; if ({mem_address, mem_byteena, mem_data, mem_wren} !== '0) begin failures++; $display("FAIL reset_mem got=%h/%b/%h/%b exp=0", mem_address, mem_byteena, mem_data, mem_wren); end
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_aligned_store();
    issue(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
    checks++; if ({mem_address, mem_byteena, mem_wren} !== {8'd4, 4'b1111, 1'b1}) begin failures++; $display("FAIL sw_acc0 got=%0d/%b/%b exp=4/1111/1", mem_address, mem_byteena, mem_wren); end
    checks++; if (mem_data !== 32'hDEADBEEF) begin failures++; $display("FAIL sw_data got=%h exp=deadbeef", mem_data); end
    checks++; if ({req_ready, resp_valid} !== 2'b00) begin failures++; $display("FAIL sw_busy got=%b exp=00", {req_ready, resp_valid}); end
    step();
    checks++; if ({resp_valid, resp_error, resp_rdata} !== {1'b1, 1'b0, 32'h0}) begin failures++; $display("FAIL sw_resp got=%b/%b/%h exp=1/0/00000000", resp_valid, resp_error, resp_rdata); end
    checks++; if ({mem_wren, mem_byteena} !== 5'b0) begin failures++; $display("FAIL sw_resp_mem got=%b/%b exp=0/0000", mem_wren, mem_byteena); end
    step();
    checks++; if ({req_ready, resp_valid} !== 2'b10) begin failures++; $display("FAIL sw_idle got=%b exp=10", {req_ready, resp_valid}); end
    checks++; if (mem[4] !== 32'hDEADBEEF) begin failures++; $display("FAIL sw_mem got=%h exp=deadbeef", mem[4]); end
  endtask

  task automatic test_byte_loads();
    mem[4] = 32'h80112233;
    issue(1'b0, 3'b000, 32'h13, 32'h0);
    checks++; if ({mem_address, mem_byteena, mem_wren} !== {8'd4, 4'b1000, 1'b0}) begin failures++; $display("FAIL lb_acc0 got=%0d/%b/%b exp=4/1000/0", mem_address, mem_byteena, mem_wren); end
    step();
    checks++; if ({resp_valid, resp_rdata} !== {1'b1, 32'hFFFFFF80}) begin failures++; $display("FAIL lb_rdata got=%b/%h exp=1/ffffff80", resp_valid, resp_rdata); end
    step();
    issue(1'b0, 3'b100, 32'h13, 32'h0);
    checks++; if ({mem_byteena, mem_wren, mem_data} !== {4'b1000, 1'b0, 32'h0}) begin failures++; $display("FAIL lbu_acc0 got=%b/%b/%h exp=1000/0/0", mem_byteena, mem_wren, mem_data); end
    step();
    checks++; if ({resp_valid, resp_rdata} !== {1'b1, 32'h00000080}) begin failures++; $display("FAIL lbu_rdata got=%b/%h exp=1/00000080", resp_valid, resp_rdata); end
    step();
  endtask

  task automatic test_half_store();
    mem[0] = 32'h55667788;
    issue(1'b1, 3'b001, 32'h1, 32'h1234ABCD);
    checks++; if ({mem_address, mem_byteena, mem_wren} !== {8'd0, 4'b0110, 1'b1}) begin failures++; $display("FAIL sh_acc0 got=%0d/%b/%b exp=0/0110/1", mem_address, mem_byteena, mem_wren); end
    checks++; if (mem_data !== 32'h34ABCD12) begin failures++; $display("FAIL sh_data got=%h exp=34abcd12", mem_data); end
    step();
    checks++; if (resp_valid !== 1'b1) begin failures++; $display("FAIL sh_resp got=%b exp=1", resp_valid); end
    step();
    checks++; if (mem[0] !== 32'h55ABCD88) begin failures++; $display("FAIL sh_mem got=%h exp=55abcd88", mem[0]); end
  endtask

  task automatic test_cross_load();
    mem[1] = 32'h44332211;
    mem[2] = 32'h88776655;
    issue(1'b0, 3'b010, 32'h6, 32'h0);
    checks++; if ({mem_address, mem_byteena, mem_wren} !== {8'd1, 4'b1100, 1'b0}) begin failures++; $display("FAIL lwx_acc0 got=%0d/%b/%b exp=1/1100/0", mem_address, mem_byteena, mem_wren); end
    step();
    checks++; if ({mem_address, mem_byteena, resp_valid} !== {8'd2, 4'b0011, 1'b0}) begin failures++; $display("FAIL lwx_acc1 got=%0d/%b/%b exp=2/0011/0", mem_address, mem_byteena, resp_valid); end
    step();
    checks++; if ({resp_valid, resp_error, resp_rdata} !== {1'b1, 1'b0, 32'h66554433}) begin failures++; $display("FAIL lwx_rdata got=%b/%b/%h exp=1/0/66554433", resp_valid, resp_error, resp_rdata); end
    step();
  endtask

  task automatic test_cross_store();
    mem[1] = 32'hAAAAAAAA;
    mem[2] = 32'hBBBBBBBB;
    issue(1'b1, 3'b010, 32'h7, 32'h11223344);
    checks++; if ({mem_address, mem_byteena, mem_wren, mem_data} !== {8'd1, 4'b1000, 1'b1, 32'h44112233}) begin failures++; $display("FAIL swx_acc0 got=%0d/%b/%b/%h exp=1/1000/1/44112233", mem_address, mem_byteena, mem_wren, mem_data); end
    step();
    checks++; if ({mem_address, mem_byteena, mem_wren} !== {8'd2, 4'b0111, 1'b1}) begin failures++; $display("FAIL swx_acc1 got=%0d/%b/%b exp=2/0111/1", mem_address, mem_byteena, mem_wren); end
    step();
    checks++; if ({resp_valid, resp_rdata} !== {1'b1, 32'h0}) begin failures++; $display("FAIL swx_resp got=%b/%h exp=1/00000000", resp_valid, resp_rdata); end
    step();
    checks++; if ({mem[2], mem[1]} !== {32'hBB112233, 32'h44AAAAAA}) begin failures++; $display("FAIL swx_mem got=%h_%h exp=bb112233_44aaaaaa", mem[2], mem[1]); end
  endtask

  task automatic test_wrap();
    mem[255] = 32'h9A000000;
    mem[0]   = 32'h11223388;
    issue(1'b0, 3'b001, 32'hFFFFFFFF, 32'h0);
    checks++; if ({mem_address, mem_byteena} !== {8'd255, 4'b1000}) begin failures++; $display("FAIL wrap_acc0 got=%0d/%b exp=255/1000", mem_address, mem_byteena); end
    step();
    checks++; if ({mem_address, mem_byteena} !== {8'd0, 4'b0001}) begin failures++; $display("FAIL wrap_acc1 got=%0d/%b exp=0/0001", mem_address, mem_byteena); end
    step();
    checks++; if ({resp_valid, resp_rdata} !== {1'b1, 32'hFFFF889A}) begin failures++; $display("FAIL wrap_rdata got=%b/%h exp=1/ffff889a", resp_valid, resp_rdata); end
    step();
  endtask

  task automatic test_error();
    issue(1'b0, 3'b011, 32'h10, 32'h0);
    checks++; if ({resp_valid, resp_error, resp_rdata, mem_wren} !== {1'b1, 1'b1, 32'h0, 1'b0}) begin failures++; $display("FAIL err_load got=%b/%b/%h/%b exp=1/1/0/0", resp_valid, resp_error, resp_rdata, mem_wren); end
    step();
    checks++; if ({req_ready, resp_valid, resp_error} !== 3'b101) begin failures++; $display("FAIL err_hold got=%b exp=101", {req_ready, resp_valid, resp_error}); end
    mem[4] = 32'h01020304;
    issue(1'b1, 3'b100, 32'h10, 32'hFFFFFFFF);
    checks++; if ({resp_valid, resp_error, mem_wren} !== 3'b110) begin failures++; $display("FAIL err_store got=%b exp=110", {resp_valid, resp_error, mem_wren}); end
    step();
    checks++; if (mem[4] !== 32'h01020304) begin failures++; $display("FAIL err_mem got=%h exp=01020304", mem[4]); end
  endtask

  task automatic test_back_to_back();
    mem[4] = 32'hCAFEBABE;
    issue(1'b0, 3'b010, 32'h10, 32'h0);
    step();
    checks++; if ({resp_valid, resp_error, resp_rdata} !== {1'b1, 1'b0, 32'hCAFEBABE}) begin failures++; $display("FAIL b2b_first got=%b/%b/%h exp=1/0/cafebabe", resp_valid, resp_error, resp_rdata); end
    req_write = 1'b0; req_funct3 = 3'b100; req_addr = 32'h11; req_valid = 1'b1;
    step();
    checks++; if ({req_ready, mem_byteena} !== {1'b1, 4'b0000}) begin failures++; $display("FAIL b2b_ignored got=%b/%b exp=1/0000", req_ready, mem_byteena); end
    step();
    req_valid = 1'b0;
    checks++; if ({req_ready, mem_byteena} !== {1'b0, 4'b0010}) begin failures++; $display("FAIL b2b_accept got=%b/%b exp=0/0010", req_ready, mem_byteena); end
    step();
    checks++; if ({resp_valid, resp_rdata} !== {1'b1, 32'h000000BA}) begin failures++; $display("FAIL b2b_second got=%b/%h exp=1/000000ba", resp_valid, resp_rdata); end
    step();
  endtask

  task automatic test_reset_mid();
    mem[1] = 32'h0;
    mem[2] = 32'h12345678;
    issue(1'b1, 3'b010, 32'h7, 32'hCAFEF00D);
    step();
    checks++; if ({mem_address, mem_wren} !== {8'd2, 1'b1}) begin failures++; $display("FAIL rst_acc1 got=%0d/%b exp=2/1", mem_address, mem_wren); end
    reset_n = 1'b0;
    #1;
    checks++; if ({mem_wren, mem_byteena, req_ready, resp_valid} !== {1'b0, 4'b0000, 1'b1, 1'b0}) begin failures++; $display("FAIL rst_drop got=%b/%b/%b/%b exp=0/0000/1/0", mem_wren, mem_byteena, req_ready, resp_valid); end
    step();
    @(negedge clock);
    reset_n = 1'b1;
    step();
    checks++; if ({mem[2], mem[1]} !== {32'h12345678, 32'h0D000000}) begin failures++; $display("FAIL rst_mem got=%h_%h exp=12345678_0d000000", mem[2], mem[1]); end
    checks++; if ({req_ready, resp_valid} !== 2'b10) begin failures++; $display("FAIL rst_ready got=%b exp=10", {req_ready, resp_valid}); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    test_reset();
    test_aligned_store();
    test_byte_loads();
    test_half_store();
    test_cross_load();
    test_cross_store();
    test_wrap();
    test_error();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Processor-side initiator for the byte-enabled word data memory: accepts one load/store request at a time from the execute stage.
- Drives the memory's word address, byte enables, write data and write enable, and aligns/extends returned read data.
- Supports RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW.
- Splits word-crossing (misaligned) accesses into two sequential memory accesses.

Parameters:
DATA_BITS, 10, byte-address width of the data memory; memory holds 2**DATA_BITS bytes, word address is DATA_BITS-2 bits

Ports:
clock  input  1  rising-edge clock shared with the data memory
reset_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  unit can accept a request
req_write  input  1  1 = store, 0 = load
req_funct3  input  3  000 B, 001 H, 010 W, 100 BU, 101 HU
req_addr  input  32  byte address; bits above DATA_BITS-1 ignored
req_wdata  input  32  store data, right-justified
resp_valid  output  1  one-cycle completion pulse
resp_rdata  output  32  extended load data; 0 for stores and errors
resp_error  output  1  illegal funct3, valid with resp_valid
mem_address  output  DATA_BITS-2  memory word address
mem_byteena  output  4  memory byte lane enables
mem_data  output  32  memory write data
mem_wren  output  1  memory write enable
mem_q  input  32  memory read data; combinational from mem_address

Behaviour:
- Memory contract: read is combinational (mem_q follows mem_address in the same cycle); write occurs at the rising clock edge while mem_wren=1, on lanes with mem_byteena set.
- Reset, asynchronous: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_error=0, all mem_* outputs=0.
- mem_* outputs are decoded from registered state, so asserting reset_n=0 drops mem_wren immediately.
- States: IDLE, ACC0, ACC1, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid at an edge, register write, funct3, addr, wdata.
  - Next state is RESP with error=1 if funct3 ∈ {011,110,111}, or if a store has funct3[2]=1. Otherwise next state is ACC0.
- Notation: o = addr[1:0]; n = 1/2/4 for B/H/W; w = addr[DATA_BITS-1:2]. Crossing iff o+n > 4.
- ACC0:
  - mem_address=w; mem_byteena = lanes o..min(3,o+n-1).
  - Store: mem_wren=1, mem_data = wdata rotated left by 8*o.
  - Load: mem_wren=0, mem_data=0; capture the enabled lanes of mem_q at the edge.
  - Next state: ACC1 if crossing, else RESP.
- ACC1:
  - mem_address = w+1, wrapping modulo 2**(DATA_BITS-2).
  - mem_byteena = lanes 0..o+n-5.
  - Same data rotation and capture rules as ACC0.
  - Next state: RESP.
- Load assembly: captured 4-byte buffer rotated right by 8*o gives bytes 0..n-1.
  - B/H: sign-extend from bit 7/15.
  - BU/HU: zero-extend.
  - W: pass through.
- RESP:
  - req_ready=0, resp_valid=1 for exactly one cycle, carrying resp_rdata/resp_error.
  - Next state: IDLE.
  - resp_rdata/resp_error hold their values until the next RESP.
- In IDLE and RESP, all mem_* outputs are 0.
- req_ready=0 in ACC0, ACC1 and RESP; req_valid is ignored there.
- Latency, with the accept edge at cycle T:
  - Aligned: resp_valid in cycle T+2.
  - Crossing: resp_valid in cycle T+3.
  - Error: resp_valid in cycle T+1, and no memory access occurs.
- A request can be accepted in the cycle after resp_valid (back-to-back throughput is 1 per 3 cycles when aligned).
- Reset during ACC1 of a split store: the first half stays written, the second half is never written, and no response is issued.

Test Plan:
- Aligned store: SW, addr=0x10, wdata=0xDEADBEEF. Required: ACC0 with mem_address=4, byteena=1111, mem_data=0xDEADBEEF, wren=1; then resp_valid at T+2 with rdata=0, error=0.
- Byte loads: memory word 4 = 0x80112233. LB addr=0x13 returns 0xFFFFFF80; LBU addr=0x13 returns 0x00000080. Both with byteena=1000 and wren=0.
- Halfword store: SH, addr=0x1, wdata=0x1234ABCD. Required: byteena=0110, mem_data=0x34ABCD12. Memory bytes 1,2 become CD,AB; bytes 0,3 are unchanged.
- Crossing load: words 1 and 2 hold 0x44332211 and 0x88776655; LW addr=0x6. Required: ACC0 with addr=1, byteena=1100; then ACC1 with addr=2, byteena=0011; then rdata=0x66554433 at T+3.
- Crossing store: SW, addr=0x7, wdata=0x11223344. Required: addr=1, byteena=1000, data=0x44112233; then addr=2, byteena=0111. Reading back gives bytes 7..10 = 44,33,22,11.
- Wrap: LH at byte address 2**DATA_BITS-1 reads lane 3 of the last word, then lane 0 of word 0.
- Error: funct3=011 gives no mem_wren and resp_error=1 at T+1.
- Reset mid-access: reset asserted during ACC1 of a split store drops wren immediately; word 2 is unchanged; req_ready=1 after release.
